// File: rtl/rv32_lsu.sv
// rv32_lsu: RV32I load/store unit sitting between the execute stage and a
// word-wide data memory that has an asynchronous read and one word write
// enable. It extracts and extends byte/halfword lanes on loads, merges SB/SH
// into the existing word with a read-modify-write, and drives word indices.
//
// Build option: define RV32_LSU_ERR_CHECK_EN to enable misalignment and
// illegal-funct3 detection (rsp_err_o). Without it, rsp_err_o is tied low,
// misaligned addresses are force-aligned, illegal load funct3 acts as LW and
// illegal store funct3 acts as SW.
module rv32_lsu #(
  parameter int ADDR_W = 13
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W+1:0] addr_q;
  logic [2:0]        f3_q;
  logic [31:0]       wd_q;
  logic [31:0]       rdata_q;
  logic              accept_s;
  logic              err_s;
  logic [2:0]        f3_s;
`ifdef RV32_LSU_ERR_CHECK_EN
  logic              err_q;
`endif

  // funct3 encodings this unit understands for the given direction.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    case (f3)
      3'b000, 3'b001, 3'b010: ok = 1'b1;
      3'b100, 3'b101:         ok = ~we;
      default:                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Halfword needs addr[0]=0, word needs addr[1:0]=0.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3[1:0])
      2'b01:   bad = off[0];
      2'b10:   bad = (off != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  // Little-endian lane select plus sign/zero extension of a loaded word.
  function automatic logic [31:0] load_extract(input logic [2:0] f3,
                                               input logic [1:0] off,
                                               input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      default: b = word[31:24];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = word;
    endcase
    return r;
  endfunction

  // Replace the addressed byte/half of the old word with the store data.
  function automatic logic [31:0] store_merge(input logic [2:0] f3,
                                              input logic [1:0] off,
                                              input logic [31:0] old_w,
                                              input logic [31:0] wdata);
    logic [31:0] r;
    r = old_w;
    case (f3[1:0])
      2'b00: begin
        case (off)
          2'b00:   r[7:0]   = wdata[7:0];
          2'b01:   r[15:8]  = wdata[7:0];
          2'b10:   r[23:16] = wdata[7:0];
          default: r[31:24] = wdata[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) r[31:16] = wdata[15:0];
        else        r[15:0]  = wdata[15:0];
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  assign accept_s = req_valid_i & (state_q == S_IDLE);

  // Classify the incoming request: error flag and the funct3 actually used.
  always_comb begin
    err_s = 1'b0;
    f3_s  = req_funct3_i;
`ifdef RV32_LSU_ERR_CHECK_EN
    if (!f3_legal(req_we_i, req_funct3_i) || misaligned(req_funct3_i, req_addr_i[1:0])) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
`else
    if (f3_legal(req_we_i, req_funct3_i)) begin
      f3_s = req_funct3_i;
    end else begin
      f3_s = 3'b010;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (!req_valid_i)            state_d = S_IDLE;
        else if (err_s)              state_d = S_RESP;
        else if (!req_we_i)          state_d = S_LOAD;
        else if (f3_s[1:0] == 2'b10) state_d = S_WRITE;
        else                         state_d = S_RMW_RD;
      end
      S_LOAD:   state_d = S_RESP;
      S_RMW_RD: state_d = S_WRITE;
      S_WRITE:  state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Request capture, load result and merged store data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      f3_q    <= 3'b000;
      wd_q    <= 32'h0000_0000;
      rdata_q <= 32'h0000_0000;
`ifdef RV32_LSU_ERR_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else if (accept_s) begin
      addr_q  <= req_addr_i[ADDR_W+1:0];
      f3_q    <= f3_s;
      wd_q    <= req_wdata_i;
      rdata_q <= 32'h0000_0000;
`ifdef RV32_LSU_ERR_CHECK_EN
      err_q   <= err_s;
`endif
    end else if (state_q == S_LOAD) begin
      rdata_q <= load_extract(f3_q, addr_q[1:0], mem_rd_i);
    end else if (state_q == S_RMW_RD) begin
      wd_q    <= store_merge(f3_q, addr_q[1:0], mem_rd_i, wd_q);
    end
  end

  // Outputs decoded from the state register so reset drops them at once.
  always_comb begin
    req_ready_o = (state_q == S_IDLE);
    rsp_valid_o = 1'b0;
    rsp_rdata_o = 32'h0000_0000;
    rsp_err_o   = 1'b0;
    mem_addr_o  = 32'h0000_0000;
    mem_we_o    = 1'b0;
    mem_wd_o    = 32'h0000_0000;
    case (state_q)
      S_LOAD, S_RMW_RD: begin
        mem_addr_o = {{(32-ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
      end
      S_WRITE: begin
        mem_addr_o = {{(32-ADDR_W){1'b0}}, addr_q[ADDR_W+1:2]};
        mem_we_o   = 1'b1;
        mem_wd_o   = wd_q;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = rdata_q;
`ifdef RV32_LSU_ERR_CHECK_EN
        rsp_err_o   = err_q;
`else
        rsp_err_o   = 1'b0;
`endif
      end
      default: begin
        rsp_valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/rv32_lsu.md
Name: rv32_lsu

Overview:
- Load/store unit between the RV32I core's execute stage and the word-wide data memory.
- The data memory has a single word write enable, no byte enables, and an asynchronous read.
- This block does byte/halfword lane extraction, sign/zero extension on loads, and read-modify-write merging for SB/SH.
- It converts byte addresses into the word index the memory expects.
- Requests use a valid/ready handshake; responses are a one-cycle pulse.

Parameters:
- ADDR_W, 13: word-index width driven to memory (8192 words); mem_addr bits above ADDR_W are 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  LSU can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; stores use SB 000, SH 001, SW 010.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the byte/half is taken from the low bits.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  extended load data; valid while rsp_valid is high, 0 otherwise.
- rsp_err  out  1  misaligned or illegal funct3; qualified by rsp_valid.
- mem_addr  out  32  word index = {0, addr[ADDR_W+1:2]}.
- mem_we  out  1  memory word write enable.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory asynchronous read data.

Behaviour:
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- Reset state is IDLE, with:
  - req_ready=1
  - rsp_valid=0, rsp_rdata=0, rsp_err=0
  - mem_we=0, mem_addr=0, mem_wd=0
- IDLE: on req_valid&req_ready, register addr, funct3, we, wdata.
- Illegal cases:
  - funct3 011/110/111 on a load, or any funct3 other than 000/001/010 on a store.
  - Misaligned: half with addr[0]=1, or word with addr[1:0]!=0.
  - Any illegal case goes to RESP with rsp_err=1 and rsp_rdata=0; no memory write ever occurs.
- Legal load: IDLE -> LOAD. In LOAD, mem_addr is driven and mem_rd is sampled at the end of the cycle.
- Load lane extraction (little-endian):
  - Byte lane is addr[1:0]; half lane is addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
  - The result is registered into rsp_rdata; then go to RESP.
- SW: IDLE -> WRITE. mem_wd = wdata.
- SB/SH: IDLE -> RMW_RD, which latches mem_rd.
  - Merge: replace the addressed byte with wdata[7:0], or the addressed half with wdata[15:0].
  - Then RMW_RD -> WRITE.
- WRITE: mem_we=1 for exactly one cycle with merged/full data, then go to RESP.
- RESP: rsp_valid=1 for one cycle, then IDLE.
- Timing and throughput:
  - Latency from accept edge to rsp_valid: load/SW 2 cycles, SB/SH 3 cycles, error 1 cycle.
  - Back-to-back requests are accepted only when IDLE.
- mem_addr is held constant from LOAD/RMW_RD through WRITE; it is 0 in IDLE and RESP.
- mem_we and mem_wd are decoded from the state register, so an async reset drops mem_we immediately.
- Reset during RMW_RD or WRITE: the transaction is abandoned and no response is issued. If rst asserts before the WRITE-state clock edge, the memory is not written.
- Address bits above ADDR_W+1 are ignored (wrap modulo memory size).
- No response backpressure: the core must consume rsp_valid in its cycle.

Optional Feature:
- Macro: RV32_LSU_ERR_CHECK_EN.
- Defined: misalignment and illegal-funct3 detection as above; rsp_err is driven.
- Undefined:
  - rsp_err is tied 0.
  - Misaligned addresses are force-aligned (half ignores addr[0]; word ignores addr[1:0]).
  - Illegal load funct3 is treated as LW; illegal store funct3 is treated as SW.
  - There is no error path.

Test Plan:
- Word load: memory word 4 = 0xDEADBEEF; LW addr 0x10 -> rsp_valid 2 cycles after accept, rsp_rdata=0xDEADBEEF, rsp_err=0, mem_we never high.
- Byte loads: same word; LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- Byte store: word 4 = 0x11223344; SB addr 0x11 wdata 0xFFFFFFAA -> mem_we exactly 1 cycle with mem_addr=4, mem_wd=0x1122AA44; a subsequent LW 0x10 returns 0x1122AA44.
- Half/word stores: SH 0x12 wdata 0x5566 -> word 0x55663344; SW 0x10 0xCAFEF00D -> single write, no RMW_RD cycle, rsp 2 cycles after accept.
- Errors (with RV32_LSU_ERR_CHECK_EN): SH 0x21 and LW 0x22 -> rsp_valid next cycle, rsp_err=1, rsp_rdata=0, mem_we stays 0, memory unchanged.
- Reset mid-op: assert rst during RMW_RD of SB -> mem_we stays 0, req_ready=1 immediately, no rsp_valid, memory unchanged.
